serial_alu_ctrl: RTL and testbench

//   Bit-serial initiator/sequencer for the 1-bit ALU slice: accepts WIDTH-bit operands
//   and an opcode, feeds one bit pair per cycle (LSB first) into a single slice, ripples

---
 rtl/serial_alu_ctrl_pkg.sv | 19 +
 rtl/serial_alu_ctrl_bit_slice.sv | 35 +++
 rtl/serial_alu_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_alu_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice.
//   op_e    : ALU opcodes as presented on the 2-bit op input
//   state_e : sequencer FSM state encoding
package serial_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_NOR = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_alu_ctrl_bit_slice.sv
// alu_bit_slice: purely combinational 1-bit ALU slice.
//   a, b : operand bits
//   c    : carry in (only meaningful for OP_ADD)
//   op   : operation select
//   d    : result bit
//   e    : carry out (full-adder majority for OP_ADD, 0 otherwise)
module alu_bit_slice
  import serial_alu_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  op_e  op,
  output logic d,
  output logic e
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    d = 1'b0;
    e = 1'b0;
    unique case (op)
      OP_ADD: begin
        d = a ^ b ^ c;
        e = (a & b) | (a & c) | (b & c);
      end
      OP_AND: d = a & b;
      OP_NOR: d = ~(a | b);
      OP_XOR: d = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial sequencer around one alu_bit_slice.
// Accepts WIDTH-bit operands and an opcode, feeds one bit pair per cycle
// (LSB first) through the slice, ripples the carry through a register and
// assembles the result.
//   clk    : clock, all state on rising edge
//   rst    : synchronous active-high reset
//   start  : request, accepted in IDLE or DONE
//   op     : 00 ADD, 01 AND, 10 NOR, 11 XOR
//   a, b   : operands, captured on accept
//   cin    : carry-in, ADD only
//   busy   : high while the serial operation runs
//   done   : one-cycle pulse when result/cout become valid
//   result : final result, held until the next completion
//   cout   : carry-out for ADD, 0 otherwise
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, part;
  op_e              op_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;
  logic             slice_d, slice_e;
  logic [WIDTH-1:0] part_nxt;

  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign part_nxt = {slice_d, part[WIDTH-1:1]};

  alu_bit_slice u_slice (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (carry),
    .op (op_q),
    .d  (slice_d),
    .e  (slice_e)
  );

  // Next-state and FSM outputs. start is ignored while RUN.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the datapath registers are reset too, not just the FSM, so an
      // aborted operation leaves no stale operands, carry or visible result.
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      part   <= '0;
      op_q   <= OP_ADD;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        op_q  <= op_e'(op);
        carry <= (op_e'(op) == OP_ADD) ? cin : 1'b0;
        cnt   <= '0;
        part  <= '0;
      end else if (state == S_RUN) begin
        // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at LSB.
        part  <= part_nxt;
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= slice_e;
        if (last) begin
          result <= part_nxt;
          cout   <= (op_q == OP_ADD) ? slice_e : 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
module tb_serial_alu_ctrl;
  import serial_alu_ctrl_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
    int               acc_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] result;
  logic             cout;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   busy_run = 0;
  exp_t exp_q[$];

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input logic ci);
    exp_t r;
    logic [WIDTH:0] sum;
    r.co = 1'b0;
    r.acc_cyc = 0;
    case (o)
      2'b00: begin
        sum  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        r.res = sum[WIDTH-1:0];
        r.co  = sum[WIDTH];
      end
      2'b01:   r.res = x & y;
      2'b10:   r.res = ~(x | y);
      default: r.res = x ^ y;
    endcase
    return r;
  endfunction

  // Scoreboard: each done pulse pops one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) busy_run = 0;
    else if (busy === 1'b1) busy_run++;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("cout", 32'(cout), 32'(e.co));
        check("latency", 32'(cyc - e.acc_cyc), 32'(WIDTH));
        check("busy_cycles", 32'(busy_run), 32'(WIDTH));
      end
      busy_run = 0;
    end
  end

  // Drive a request; must be called away from the rising edge with the DUT
  // in IDLE or DONE. Returns #1 after the accepting edge with start low.
  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input logic ci, input bit hold = 0);
    exp_t e;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    cin = ci;
    @(posedge clk);
    #1;
    e = model(o, x, y, ci);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    if (!hold) start = 1'b0;
  endtask

  // Returns at the falling edge of the done cycle; done_cyc reports its cycle.
  task automatic wait_done(output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2;
    exp_t e;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    // Directed operations, including carry-out and cin-ignored cases.
    issue(2'b00, 8'hFF, 8'h01, 1'b0); wait_done(d1);
    issue(2'b00, 8'h7F, 8'h00, 1'b1); wait_done(d1);
    issue(2'b01, 8'hA5, 8'h3C, 1'b1); wait_done(d1);
    issue(2'b10, 8'hA5, 8'h3C, 1'b1); wait_done(d1);
    issue(2'b11, 8'hA5, 8'h3C, 1'b1); wait_done(d1);
    issue(2'b00, 8'hFF, 8'hFF, 1'b1); wait_done(d1);
    // Idle gap, then result must still hold its last value.
    repeat (3) @(negedge clk);
    check("hold_result", 32'(result), 32'hFF);
    check("hold_cout", 32'(cout), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(3)), 8'($urandom), 8'($urandom), 1'($urandom));
      wait_done(d1);
    end

    // start pulsed mid-run with different operands must be ignored.
    issue(2'b00, 8'h10, 8'h20, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; a = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d1);
    check("ignored_start_result", 32'(result), 32'h30);

    // Reset at RUN cycle 4 aborts without a done pulse.
    issue(2'b00, 8'h12, 8'h34, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(done), 32'd0);
    end

    // start held through DONE: second op accepted back-to-back.
    issue(2'b00, 8'hC8, 8'h64, 1'b0, 1'b1);
    a = 8'h0F; b = 8'hF0; op = 2'b11; cin = 1'b0;
    wait_done(d1);
    @(posedge clk); #1;
    e = model(2'b11, 8'h0F, 8'hF0, 1'b0);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    start = 1'b0;
    wait_done(d2);
    check("done_spacing", 32'(d2 - d1), 32'(WIDTH + 1));
    check("b2b_result", 32'(result), 32'hFF);

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
